loadunit: RTL and testbench

Data-memory load path for the four-bank (word-interleaved) data memory, the read-side counterpart of the store data / byte-write-enable generation. The unit accepts scalar loads (`lb`/`lh`/`lw`/`lbu`/`lhu`) and vector unit-stride loads from the VLSU, and issues bank reads. It captures bank data one cycle later, then aligns and sign- or zero-extends it. Results return through a 2-entry response FIFO with a ready/valid handshake.

---
 rtl/loadunit_if.sv | 76 +++++++
 rtl/loadunit.sv | 186 ++++++++++++++++++
 tb/tb_loadunit.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/loadunit_if.sv
// loadunit_if: bundle of every request, bank-read and response signal of the
// data-memory load path.
//   slave  : the load unit side (takes requests and bank data, drives strobes,
//            bank addresses and responses)
//   master : the requester / memory / consumer side
// Port summary:
//   req_*        load request with ready/valid handshake (scalar and vector)
//   bank_rd_k    read strobe for bank k, bank_addr_k its word address
//   bank_rdata_k data from bank k, valid the cycle after its strobe
//   rsp_*        response FIFO head with ready/valid handshake
`ifndef DATAMEM_BITS
`define DATAMEM_BITS 16
`endif

interface loadunit_if #(
    parameter int DATAMEM_BITS = `DATAMEM_BITS
) ();
    logic                    req_valid;
    logic                    req_ready;
    logic [DATAMEM_BITS-1:0] req_addr;
    logic [1:0]              req_byte_offset;
    logic [1:0]              req_load_select;
    logic                    req_unsigned;
    logic                    req_is_vltype;
    logic [DATAMEM_BITS-1:0] req_vaddr0;
    logic [DATAMEM_BITS-1:0] req_vaddr1;
    logic [DATAMEM_BITS-1:0] req_vaddr2;
    logic [DATAMEM_BITS-1:0] req_vaddr3;

    logic                    bank_rd_0;
    logic                    bank_rd_1;
    logic                    bank_rd_2;
    logic                    bank_rd_3;
    logic [DATAMEM_BITS-1:0] bank_addr_0;
    logic [DATAMEM_BITS-1:0] bank_addr_1;
    logic [DATAMEM_BITS-1:0] bank_addr_2;
    logic [DATAMEM_BITS-1:0] bank_addr_3;
    logic [31:0]             bank_rdata_0;
    logic [31:0]             bank_rdata_1;
    logic [31:0]             bank_rdata_2;
    logic [31:0]             bank_rdata_3;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [31:0]             rsp_data0;
    logic [31:0]             rsp_data1;
    logic [31:0]             rsp_data2;
    logic [31:0]             rsp_data3;
    logic                    rsp_misaligned;

    modport slave (
        input  req_valid, req_addr, req_byte_offset, req_load_select,
               req_unsigned, req_is_vltype,
               req_vaddr0, req_vaddr1, req_vaddr2, req_vaddr3,
        output req_ready,
        output bank_rd_0, bank_rd_1, bank_rd_2, bank_rd_3,
               bank_addr_0, bank_addr_1, bank_addr_2, bank_addr_3,
        input  bank_rdata_0, bank_rdata_1, bank_rdata_2, bank_rdata_3,
        output rsp_valid, rsp_data0, rsp_data1, rsp_data2, rsp_data3,
               rsp_misaligned,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_addr, req_byte_offset, req_load_select,
               req_unsigned, req_is_vltype,
               req_vaddr0, req_vaddr1, req_vaddr2, req_vaddr3,
        input  req_ready,
        input  bank_rd_0, bank_rd_1, bank_rd_2, bank_rd_3,
               bank_addr_0, bank_addr_1, bank_addr_2, bank_addr_3,
        output bank_rdata_0, bank_rdata_1, bank_rdata_2, bank_rdata_3,
        input  rsp_valid, rsp_data0, rsp_data1, rsp_data2, rsp_data3,
               rsp_misaligned,
        output rsp_ready
    );
endinterface

// File: rtl/loadunit.sv
// loadunit: load path of the four-bank word-interleaved data memory.
// Accepts scalar (lb/lh/lw/lbu/lhu) and vector unit-stride loads, strobes
// the bank reads in the accept cycle, captures bank data one cycle later,
// aligns and extends it, and returns results through a 2-entry FIFO.
// Ports:
//   clk  - single clock, rising edge
//   nrst - asynchronous active-low reset
//   lu   - loadunit_if.slave: request, bank-read and response signals
`ifndef DATAMEM_BITS
`define DATAMEM_BITS 16
`endif

module loadunit #(
    parameter int DATAMEM_BITS = `DATAMEM_BITS
) (
    input  logic       clk,
    input  logic       nrst,
    loadunit_if.slave  lu
);
    localparam int DATA_W = 32;
    typedef logic [DATA_W-1:0] word_t;

    typedef struct packed {
        logic  mis;
        word_t d3;
        word_t d2;
        word_t d1;
        word_t d0;
    } entry_t;

    logic       accept;
    logic       mis_req;
    logic       rsp_vld;
    logic       pop;
    logic       push;
    logic [2:0] occ;

    logic       vld_p1;
    logic [1:0] bank_p1;
    logic [1:0] off_p1;
    logic [1:0] sel_p1;
    logic       uns_p1;
    logic       vec_p1;
    logic       mis_p1;

    word_t      word_p1;
    entry_t     push_e;
    entry_t     fifo_q [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;

    // Shift the addressed byte/half down to bit 0 and extend from its top bit.
    function automatic word_t extend_load(word_t w, logic [1:0] off,
                                          logic [1:0] sel, logic uns);
        word_t                    sh;
        logic signed [7:0]        b_s;
        logic signed [15:0]       h_s;
        logic signed [DATA_W-1:0] ext;
        sh  = w >> {off, 3'b000};
        b_s = sh[7:0];
        h_s = sh[15:0];
        case (sel)
            2'd0: begin
                ext = b_s;
                return uns ? {24'd0, sh[7:0]} : word_t'(ext);
            end
            2'd1: begin
                ext = h_s;
                return uns ? {16'd0, sh[15:0]} : word_t'(ext);
            end
            default: return sh;
        endcase
    endfunction

    // Stage 0: accept and bank strobes
    always_comb begin
        rsp_vld = (count != 2'd0);
        pop     = rsp_vld & lu.rsp_ready;
        // Occupancy after this edge; a new request must still find room
        // in the FIFO by the time it reaches stage 1.
        occ     = {1'b0, count} + {2'b00, vld_p1} - {2'b00, pop};
        lu.req_ready = nrst & (occ < 3'd2);
        accept  = lu.req_valid & lu.req_ready;
        mis_req = !lu.req_is_vltype &&
                  ((lu.req_load_select == 2'd3) ||
                   (lu.req_load_select == 2'd1 && lu.req_byte_offset[0]) ||
                   (lu.req_load_select == 2'd2 && lu.req_byte_offset != 2'd0));
    end

    always_comb begin
        lu.bank_rd_0   = 1'b0;
        lu.bank_rd_1   = 1'b0;
        lu.bank_rd_2   = 1'b0;
        lu.bank_rd_3   = 1'b0;
        lu.bank_addr_0 = '0;
        lu.bank_addr_1 = '0;
        lu.bank_addr_2 = '0;
        lu.bank_addr_3 = '0;
        if (accept) begin
            if (lu.req_is_vltype) begin
                lu.bank_rd_0   = 1'b1;
                lu.bank_rd_1   = 1'b1;
                lu.bank_rd_2   = 1'b1;
                lu.bank_rd_3   = 1'b1;
                lu.bank_addr_0 = lu.req_vaddr0;
                lu.bank_addr_1 = lu.req_vaddr1;
                lu.bank_addr_2 = lu.req_vaddr2;
                lu.bank_addr_3 = lu.req_vaddr3;
            end else if (!mis_req) begin
                case (lu.req_addr[1:0])
                    2'd0: begin lu.bank_rd_0 = 1'b1; lu.bank_addr_0 = lu.req_addr; end
                    2'd1: begin lu.bank_rd_1 = 1'b1; lu.bank_addr_1 = lu.req_addr; end
                    2'd2: begin lu.bank_rd_2 = 1'b1; lu.bank_addr_2 = lu.req_addr; end
                    default: begin lu.bank_rd_3 = 1'b1; lu.bank_addr_3 = lu.req_addr; end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) vld_p1 <= 1'b0;
        else       vld_p1 <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            bank_p1 <= lu.req_addr[1:0];
            off_p1  <= lu.req_byte_offset;
            sel_p1  <= lu.req_load_select;
            uns_p1  <= lu.req_unsigned;
            vec_p1  <= lu.req_is_vltype;
            mis_p1  <= mis_req;
        end
    end

    // Stage 1: align bank data and push into the response FIFO
    always_comb begin
        case (bank_p1)
            2'd0:    word_p1 = lu.bank_rdata_0;
            2'd1:    word_p1 = lu.bank_rdata_1;
            2'd2:    word_p1 = lu.bank_rdata_2;
            default: word_p1 = lu.bank_rdata_3;
        endcase
        push   = vld_p1;
        push_e = '0;
        if (vec_p1) begin
            push_e.d0 = lu.bank_rdata_0;
            push_e.d1 = lu.bank_rdata_1;
            push_e.d2 = lu.bank_rdata_2;
            push_e.d3 = lu.bank_rdata_3;
        end else if (mis_p1) begin
            push_e.mis = 1'b1;
        end else begin
            push_e.d0 = extend_load(word_p1, off_p1, sel_p1, uns_p1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= push_e;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign lu.rsp_valid      = rsp_vld;
    assign lu.rsp_data0      = fifo_q[rd_ptr].d0;
    assign lu.rsp_data1      = fifo_q[rd_ptr].d1;
    assign lu.rsp_data2      = fifo_q[rd_ptr].d2;
    assign lu.rsp_data3      = fifo_q[rd_ptr].d3;
    assign lu.rsp_misaligned = fifo_q[rd_ptr].mis;

endmodule

// File: tb/tb_loadunit.sv
// tb_loadunit: randomized and directed bench for loadunit with a byte-level
// reference model and an in-order scoreboard of expected responses.
module tb_loadunit;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    loadunit_if #(.DATAMEM_BITS(AW)) lu ();
    loadunit #(.DATAMEM_BITS(AW)) dut (.clk(clk), .nrst(nrst), .lu(lu));

    logic [31:0] mem [0:(1<<AW)-1];

    typedef struct {
        logic [128:0] r;
        int           c;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_acc  = 0;
    int n_pop  = 0;
    int last_lat = 0;
    logic [128:0] last_rsp = '0;

    logic [43:0]  s_act;
    logic [43:0]  s_exp;
    logic [128:0] m_r;
    logic [128:0] m_got;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: byte-addressed view of the word, size = 1 << select.
    function automatic logic [128:0] model(logic [AW-1:0] a, logic [1:0] off, logic [1:0] sel,
                                          logic uns, logic vec, logic [AW-1:0] v0,
                                          logic [AW-1:0] v1, logic [AW-1:0] v2, logic [AW-1:0] v3);
        int     size;
        longint v;
        if (vec) return {1'b0, mem[v3], mem[v2], mem[v1], mem[v0]};
        size = (sel == 2'd3) ? 0 : (1 << sel);
        if (size == 0 || (int'(off) % size) != 0) return {1'b1, 128'd0};
        v = longint'(mem[a]) >> (8 * int'(off));
        v = v % (64'sd1 <<< (8 * size));
        if (!uns && v >= (64'sd1 <<< (8 * size - 1))) v = v - (64'sd1 <<< (8 * size));
        return {1'b0, 96'd0, v[31:0]};
    endfunction

    function automatic logic [43:0] exp_strobe(logic [AW-1:0] a, logic mis, logic vec,
                                               logic [AW-1:0] v0, logic [AW-1:0] v1,
                                               logic [AW-1:0] v2, logic [AW-1:0] v3);
        logic [3:0]    rd;
        logic [AW-1:0] ad [4];
        int            b;
        if (vec) return {4'hF, v3, v2, v1, v0};
        if (mis) return '0;
        rd = '0;
        for (int k = 0; k < 4; k++) ad[k] = '0;
        b = int'(a) % 4;
        rd[b] = 1'b1;
        ad[b] = a;
        return {rd, ad[3], ad[2], ad[1], ad[0]};
    endfunction

    // Bank memories: data one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        lu.bank_rdata_0 <= lu.bank_rd_0 ? mem[lu.bank_addr_0] : $urandom();
        lu.bank_rdata_1 <= lu.bank_rd_1 ? mem[lu.bank_addr_1] : $urandom();
        lu.bank_rdata_2 <= lu.bank_rd_2 ? mem[lu.bank_addr_2] : $urandom();
        lu.bank_rdata_3 <= lu.bank_rd_3 ? mem[lu.bank_addr_3] : $urandom();
    end

    always @(posedge clk) cyc++;

    // Monitor: mid-cycle sampling of strobes and the response head.
    always @(negedge clk) begin
        if (nrst) begin
            s_act = {lu.bank_rd_3, lu.bank_rd_2, lu.bank_rd_1, lu.bank_rd_0,
                     lu.bank_addr_3, lu.bank_addr_2, lu.bank_addr_1, lu.bank_addr_0};
            if (lu.req_valid && lu.req_ready) begin
                m_r = model(lu.req_addr, lu.req_byte_offset, lu.req_load_select, lu.req_unsigned,
                            lu.req_is_vltype, lu.req_vaddr0, lu.req_vaddr1, lu.req_vaddr2, lu.req_vaddr3);
                s_exp = exp_strobe(lu.req_addr, m_r[128], lu.req_is_vltype,
                                   lu.req_vaddr0, lu.req_vaddr1, lu.req_vaddr2, lu.req_vaddr3);
                check("strobe", 160'(s_act), 160'(s_exp));
                q.push_back('{r: m_r, c: cyc});
                n_acc++;
            end else begin
                check("idle_strobe", 160'(s_act), 160'(0));
            end
            if (lu.rsp_valid) begin
                m_got = {lu.rsp_misaligned, lu.rsp_data3, lu.rsp_data2, lu.rsp_data1, lu.rsp_data0};
                if (q.size() == 0) begin
                    check("rsp_unexpected", 160'(1), 160'(0));
                end else begin
                    check("rsp", 160'(m_got), 160'(q[0].r));
                    if (lu.rsp_ready) begin
                        last_rsp = m_got;
                        last_lat = cyc - q[0].c;
                        void'(q.pop_front());
                        n_pop++;
                    end
                end
            end
        end
    end

    task automatic send(input logic [AW-1:0] a, input logic [1:0] off, input logic [1:0] sel,
                        input logic uns, input logic vec, input logic [AW-1:0] v0,
                        input logic [AW-1:0] v1, input logic [AW-1:0] v2, input logic [AW-1:0] v3);
        logic acc;
        lu.req_addr = a; lu.req_byte_offset = off; lu.req_load_select = sel;
        lu.req_unsigned = uns; lu.req_is_vltype = vec;
        lu.req_vaddr0 = v0; lu.req_vaddr1 = v1; lu.req_vaddr2 = v2; lu.req_vaddr3 = v3;
        lu.req_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = lu.req_ready;
            @(posedge clk);
            #1;
        end
        lu.req_valid = 1'b0;
        if (!acc) check("send_timeout", 160'(0), 160'(1));
    endtask

    task automatic wait_rsp(output logic [128:0] r, output int lat);
        int start;
        start = n_pop;
        for (int i = 0; i < 20 && n_pop == start; i++) @(posedge clk);
        #1;
        if (n_pop == start) check("rsp_timeout", 160'(0), 160'(1));
        r = last_rsp;
        lat = last_lat;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [128:0] r;
        logic [128:0] rexp;
        int lat, c0, p0;
        logic [AW-1:0] ra;

        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom();
        nrst = 1'b0;
        lu.req_valid = 1'b0; lu.req_addr = '0; lu.req_byte_offset = '0;
        lu.req_load_select = '0; lu.req_unsigned = 1'b0; lu.req_is_vltype = 1'b0;
        lu.req_vaddr0 = '0; lu.req_vaddr1 = '0; lu.req_vaddr2 = '0; lu.req_vaddr3 = '0;
        lu.rsp_ready = 1'b1;

        // Reset state
        #3;
        check("rst_rsp_valid", 160'(lu.rsp_valid), 160'(0));
        check("rst_req_ready", 160'(lu.req_ready), 160'(0));
        @(posedge clk); @(posedge clk);
        #3 nrst = 1'b1;
        #1;
        check("idle_req_ready", 160'(lu.req_ready), 160'(1));
        check("idle_rsp", 160'({lu.rsp_valid, lu.rsp_misaligned, lu.rsp_data0}), 160'(0));
        check("idle_strb", 160'({lu.bank_rd_3, lu.bank_rd_2, lu.bank_rd_1, lu.bank_rd_0}), 160'(0));
        @(posedge clk); #1;

        // lb, bank 2, offset 1, signed
        mem[6] = 32'h1234_80FF;
        send(10'h006, 2'd1, 2'd0, 1'b0, 1'b0, '0, '0, '0, '0);
        check("lb_t1_no_valid", 160'(lu.rsp_valid), 160'(0));
        wait_rsp(r, lat);
        check("lb_data", 160'(r), 160'({1'b0, 96'd0, 32'hFFFF_FF80}));
        check("lb_latency", 160'(lat), 160'(2));

        // lhu and lh, offset 2, bank 1
        mem[5] = 32'hBEEF_0000;
        send(10'h005, 2'd2, 2'd1, 1'b1, 1'b0, '0, '0, '0, '0);
        wait_rsp(r, lat);
        check("lhu_data", 160'(r), 160'({1'b0, 96'd0, 32'h0000_BEEF}));
        send(10'h005, 2'd2, 2'd1, 1'b0, 1'b0, '0, '0, '0, '0);
        wait_rsp(r, lat);
        check("lh_data", 160'(r), 160'({1'b0, 96'd0, 32'hFFFF_BEEF}));

        // Misaligned lw and reserved select
        send(10'h008, 2'd1, 2'd2, 1'b0, 1'b0, '0, '0, '0, '0);
        wait_rsp(r, lat);
        check("mis_lw", 160'(r), 160'({1'b1, 128'd0}));
        send(10'h009, 2'd0, 2'd3, 1'b1, 1'b0, '0, '0, '0, '0);
        wait_rsp(r, lat);
        check("mis_sel3", 160'(r), 160'({1'b1, 128'd0}));

        // Vector load
        mem[16] = 32'hA0; mem[17] = 32'hA1; mem[18] = 32'hA2; mem[19] = 32'hA3;
        send('0, 2'd3, 2'd3, 1'b0, 1'b1, 10'h010, 10'h011, 10'h012, 10'h013);
        wait_rsp(r, lat);
        check("vec_data", 160'(r), 160'({1'b0, 32'hA3, 32'hA2, 32'hA1, 32'hA0}));

        // Back-pressure: only two outstanding
        lu.rsp_ready = 1'b0;
        lu.req_addr = 10'h020; lu.req_byte_offset = 2'd0; lu.req_load_select = 2'd2;
        lu.req_is_vltype = 1'b0; lu.req_valid = 1'b1;
        c0 = n_acc;
        repeat (4) @(posedge clk);
        #1;
        check("bp_accepted", 160'(n_acc - c0), 160'(2));
        check("bp_req_ready", 160'(lu.req_ready), 160'(0));
        lu.req_valid = 1'b0;
        p0 = n_pop;
        lu.rsp_ready = 1'b1;
        #1;
        check("bp_slot_free", 160'(lu.req_ready), 160'(1));
        repeat (3) @(posedge clk);
        #1;
        check("bp_drained", 160'(n_pop - p0), 160'(2));

        // Throughput: 8 requests, 8 responses in 10 cycles
        c0 = n_acc; p0 = n_pop;
        for (int i = 0; i < 8; i++) begin
            lu.req_addr = 10'($urandom()); lu.req_byte_offset = 2'($urandom());
            lu.req_load_select = 2'($urandom_range(0, 2)); lu.req_unsigned = 1'($urandom());
            lu.req_is_vltype = 1'b0; lu.req_valid = 1'b1;
            @(posedge clk); #1;
        end
        lu.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("tput_acc", 160'(n_acc - c0), 160'(8));
        check("tput_rsp", 160'(n_pop - p0), 160'(8));

        // Reset with one entry in the FIFO and one in stage 1
        lu.rsp_ready = 1'b0;
        send(10'h031, 2'd0, 2'd2, 1'b0, 1'b0, '0, '0, '0, '0);
        send(10'h032, 2'd0, 2'd2, 1'b0, 1'b0, '0, '0, '0, '0);
        check("rst_mid_pre", 160'(lu.rsp_valid), 160'(1));
        #1 nrst = 1'b0;
        q.delete();
        lu.req_valid = 1'b1;
        #1;
        check("rst_mid_valid", 160'(lu.rsp_valid), 160'(0));
        check("rst_mid_data", 160'({lu.rsp_misaligned, lu.rsp_data0}), 160'(0));
        check("rst_mid_ready", 160'(lu.req_ready), 160'(0));
        check("rst_mid_strb", 160'({lu.bank_rd_3, lu.bank_rd_2, lu.bank_rd_1, lu.bank_rd_0}), 160'(0));
        lu.req_valid = 1'b0;
        @(posedge clk); @(posedge clk);
        #3 nrst = 1'b1;
        lu.rsp_ready = 1'b1;
        p0 = n_pop;
        repeat (3) @(posedge clk);
        #1;
        check("rst_no_stale", 160'(n_pop - p0), 160'(0));
        check("rst_no_valid", 160'(lu.rsp_valid), 160'(0));
        ra = 10'h047;
        rexp = model(ra, 2'd3, 2'd0, 1'b0, 1'b0, '0, '0, '0, '0);
        send(ra, 2'd3, 2'd0, 1'b0, 1'b0, '0, '0, '0, '0);
        wait_rsp(r, lat);
        check("rst_after_data", 160'(r), 160'(rexp));
        check("rst_after_lat", 160'(lat), 160'(2));

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            lu.req_valid       = ($urandom_range(0, 9) < 7);
            lu.rsp_ready       = ($urandom_range(0, 9) < 7);
            lu.req_addr        = 10'($urandom());
            lu.req_byte_offset = 2'($urandom());
            lu.req_load_select = 2'($urandom());
            lu.req_unsigned    = 1'($urandom());
            lu.req_is_vltype   = ($urandom_range(0, 4) == 0);
            lu.req_vaddr0      = 10'($urandom());
            lu.req_vaddr1      = 10'($urandom());
            lu.req_vaddr2      = 10'($urandom());
            lu.req_vaddr3      = 10'($urandom());
            @(posedge clk); #1;
        end
        lu.req_valid = 1'b0;
        lu.rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("drain_empty", 160'(q.size()), 160'(0));
        check("drain_no_valid", 160'(lu.rsp_valid), 160'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
